id_stage_module: RTL

Instruction decode stage of the 5-stage ARM pipeline. Directly downstream of the fetch stage's IF/ID register: it consumes `pc_in`/`instruction_in`, decodes the instruction and reads the 15-entry register file. It evaluates the condition field against the status flags and registers everything into the ID/EX pipeline register. It also exports source-register indices to the hazard unit and accepts the write-back port.

---
 rtl/id_stage_module.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/id_stage_module.sv
// Instruction decode stage: field decode, condition check, register file
// with write-through, and the ID/EX pipeline register.
module id_stage_module #(
  parameter int WORD_LENGTH = 32,
  parameter int REG_COUNT   = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   hazard,
  input  logic [WORD_LENGTH-1:0] pc_in,
  input  logic [WORD_LENGTH-1:0] instruction_in,
  input  logic [3:0]             status,
  input  logic                   wb_en_in,
  input  logic [3:0]             wb_dest,
  input  logic [WORD_LENGTH-1:0] wb_value,
  output logic [3:0]             src1,
  output logic [3:0]             src2,
  output logic                   two_src,
  output logic [WORD_LENGTH-1:0] pc,
  output logic [WORD_LENGTH-1:0] val_rn,
  output logic [WORD_LENGTH-1:0] val_rm,
  output logic [3:0]             exe_cmd,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   wb_en,
  output logic                   b,
  output logic                   s,
  output logic                   imm,
  output logic [11:0]            shift_operand,
  output logic [23:0]            signed_imm_24,
  output logic [3:0]             dest
);

  logic [WORD_LENGTH-1:0] rf [REG_COUNT];

  logic [3:0] cond;
  logic [1:0] mode;
  logic       i_bit;
  logic [3:0] opcode;
  logic       s_bit;
  logic [3:0] rn;
  logic [3:0] rd;
  logic [3:0] rm;

  assign cond   = instruction_in[31:28];
  assign mode   = instruction_in[27:26];
  assign i_bit  = instruction_in[25];
  assign opcode = instruction_in[24:21];
  assign s_bit  = instruction_in[20];
  assign rn     = instruction_in[19:16];
  assign rd     = instruction_in[15:12];
  assign rm     = instruction_in[3:0];

  logic       n_f, z_f, c_f, v_f;
  assign {n_f, z_f, c_f, v_f} = status;

  logic [3:0] d_cmd;
  logic       d_mr;
  logic       d_mw;
  logic       d_wb;
  logic       d_b;
  logic       d_s;
  logic       cond_ok;

  always_comb begin
    d_cmd = 4'b0000;
    d_mr  = 1'b0;
    d_mw  = 1'b0;
    d_wb  = 1'b0;
    d_b   = 1'b0;
    d_s   = 1'b0;
    unique case (mode)
      2'b00: begin
        d_s  = s_bit;
        d_wb = 1'b1;
        case (opcode)
          4'b1101: d_cmd = 4'b0001;
          4'b1111: d_cmd = 4'b1001;
          4'b0100: d_cmd = 4'b0010;
          4'b0101: d_cmd = 4'b0011;
          4'b0010: d_cmd = 4'b0100;
          4'b0110: d_cmd = 4'b0101;
          4'b0000: d_cmd = 4'b0110;
          4'b1100: d_cmd = 4'b0111;
          4'b0001: d_cmd = 4'b1000;
          4'b1010: begin
            d_cmd = 4'b0100;
            d_wb  = 1'b0;
          end
          4'b1000: begin
            d_cmd = 4'b0110;
            d_wb  = 1'b0;
          end
          default: begin
            d_wb = 1'b0;
            d_s  = 1'b0;
          end
        endcase
      end
      2'b01: begin
        d_cmd = 4'b0010;
        d_mr  = s_bit;
        d_wb  = s_bit;
        d_mw  = ~s_bit;
      end
      2'b10: d_b = 1'b1;
      2'b11: ;
    endcase
  end

  always_comb begin
    cond_ok = 1'b0;
    unique case (cond)
      4'b0000: cond_ok = z_f;
      4'b0001: cond_ok = ~z_f;
      4'b0010: cond_ok = c_f;
      4'b0011: cond_ok = ~c_f;
      4'b0100: cond_ok = n_f;
      4'b0101: cond_ok = ~n_f;
      4'b0110: cond_ok = v_f;
      4'b0111: cond_ok = ~v_f;
      4'b1000: cond_ok = c_f & ~z_f;
      4'b1001: cond_ok = ~c_f | z_f;
      4'b1010: cond_ok = n_f == v_f;
      4'b1011: cond_ok = n_f != v_f;
      4'b1100: cond_ok = ~z_f & (n_f == v_f);
      4'b1101: cond_ok = z_f | (n_f != v_f);
      4'b1110: cond_ok = 1'b1;
      4'b1111: cond_ok = 1'b0;
    endcase
  end

  assign src1    = rn;
  assign src2    = d_mw ? rd : rm;
  assign two_src = ~i_bit | d_mw;

  function automatic logic [WORD_LENGTH-1:0] rd_port(input logic [3:0] idx);
    if (idx == 4'd15)
      return pc_in;
    else if (wb_en_in && wb_dest == idx)
      return wb_value;
    else
      return rf[idx];
  endfunction

  logic [WORD_LENGTH-1:0] rn_val;
  logic [WORD_LENGTH-1:0] rm_val;

  always_comb begin
    rn_val = rd_port(src1);
    rm_val = rd_port(src2);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < REG_COUNT; k++)
        rf[k] <= '0;
    end else if (wb_en_in && wb_dest != 4'd15) begin
      rf[wb_dest] <= wb_value;
    end
  end

  // controls squashed on a failed condition or stall; data still loads
  logic ctl_ok;
  assign ctl_ok = cond_ok & ~hazard;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst || flush) begin
      pc            <= '0;
      val_rn        <= '0;
      val_rm        <= '0;
      exe_cmd       <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      wb_en         <= 1'b0;
      b             <= 1'b0;
      s             <= 1'b0;
      imm           <= 1'b0;
      shift_operand <= '0;
      signed_imm_24 <= '0;
      dest          <= '0;
    end else begin
      pc            <= pc_in;
      val_rn        <= rn_val;
      val_rm        <= rm_val;
      exe_cmd       <= d_cmd;
      mem_read      <= d_mr & ctl_ok;
      mem_write     <= d_mw & ctl_ok;
      wb_en         <= d_wb & ctl_ok;
      b             <= d_b & ctl_ok;
      s             <= d_s & ctl_ok;
      imm           <= i_bit;
      shift_operand <= instruction_in[11:0];
      signed_imm_24 <= instruction_in[23:0];
      dest          <= rd;
    end
  end

endmodule
